// File: rtl/fifo_gray_reader_pkg.sv
// Shared constants and FSM encoding for the FIFO-to-grayscale read engine.
package gray_pkg;

  // Luma weights sum to 256 so the shifted result always fits in one byte.
  localparam logic [7:0] W_R = 8'd77;
  localparam logic [7:0] W_G = 8'd150;
  localparam logic [7:0] W_B = 8'd29;
  localparam int         SHIFT = 8;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [1:0] {
    S_FETCH,
    S_LATCH,
    S_CALC,
    S_OUT
  } state_t;

endpackage

// File: rtl/fifo_gray_reader_weigh.sv
// Combinational weighted sum of one RGB pixel, truncated to a single luminance byte.
module gray_weigh
  import gray_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] r,
  input  logic [DATAWIDTH-1:0] g,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] y
);

  localparam int SW = DATAWIDTH + 8;

  logic [SW-1:0] sum;

  assign sum = SW'(r) * SW'(W_R) + SW'(g) * SW'(W_G) + SW'(b) * SW'(W_B);
  assign y   = DATAWIDTH'(sum >> SHIFT);

endmodule

// File: rtl/fifo_gray_reader.sv
// Drains R,G,B bytes from the FIFO read port, forms one gray byte per pixel and
// offers it on a valid/ready stream; reading stalls while the output is pending.
module fifo_gray_reader
  import gray_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [DATAWIDTH-1:0] fifo_data,
  output logic [DATAWIDTH-1:0] gray_data,
  output logic                 gray_valid,
  input  logic                 gray_ready,
  output logic [CNTWIDTH-1:0]  pix_count
);

  state_t               state;
  state_t               next_state;
  logic [1:0]           ch_idx;
  logic [DATAWIDTH-1:0] ch_r;
  logic [DATAWIDTH-1:0] ch_g;
  logic [DATAWIDTH-1:0] ch_b;
  logic [DATAWIDTH-1:0] weighed;

  gray_weigh #(.DATAWIDTH(DATAWIDTH)) u_weigh (
    .r(ch_r),
    .g(ch_g),
    .b(ch_b),
    .y(weighed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // The pop strobe exists only in FETCH, so LATCH/CALC/OUT can never underflow the FIFO.
  always_comb begin
    next_state = state;
    fifo_rd    = 1'b0;
    case (state)
      S_FETCH: begin
        fifo_rd = !fifo_empty && !rst;
        if (!fifo_empty) next_state = S_LATCH;
      end
      S_LATCH: next_state = (ch_idx == CH_B) ? S_CALC : S_FETCH;
      S_CALC:  next_state = S_OUT;
      S_OUT:   if (gray_ready) next_state = S_FETCH;
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_idx     <= CH_R;
      ch_r       <= '0;
      ch_g       <= '0;
      ch_b       <= '0;
      gray_data  <= '0;
      gray_valid <= 1'b0;
      pix_count  <= '0;
    end else begin
      case (state)
        S_LATCH: begin
          case (ch_idx)
            CH_R:    ch_r <= fifo_data;
            CH_G:    ch_g <= fifo_data;
            CH_B:    ch_b <= fifo_data;
            default: ;
          endcase
          ch_idx <= (ch_idx == CH_B) ? CH_R : ch_idx + 2'd1;
        end
        S_CALC: begin
          gray_data  <= weighed;
          gray_valid <= 1'b1;
        end
        S_OUT: begin
          if (gray_ready) begin
            gray_valid <= 1'b0;
            pix_count  <= pix_count + CNTWIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_gray_reader.sv
// Self-checking bench: a behavioural FIFO feeds the reader and a luma model predicts every pixel.
module tb_fifo_gray_reader;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [7:0]    fifo_data = 8'd0;
  logic [7:0]    gray_data;
  logic          gray_valid;
  logic          gray_ready = 1'b0;
  logic [CW-1:0] pix_count;

  logic [7:0] mem [0:1023];
  logic [9:0] wr_ptr = 10'd0;
  logic [9:0] rd_ptr = 10'd0;
  logic       hold_empty = 1'b0;
  int         underflows = 0;

  logic [7:0] exp_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;

  fifo_gray_reader #(.DATAWIDTH(8), .CNTWIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd),
    .fifo_data(fifo_data),
    .gray_data(gray_data),
    .gray_valid(gray_valid),
    .gray_ready(gray_ready),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

  // Behavioural FIFO: data appears on fifo_data the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fifo_empty) underflows <= underflows + 1;
      else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 10'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] ref_gray(input int r, input int g, input int b);
    int s;
    s = 77 * r + 150 * g + 29 * b;
    return 8'(s / 256);
  endfunction

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    push(r);
    push(g);
    push(b);
    exp_q.push_back(ref_gray(int'(r), int'(g), int'(b)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (gray_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic find_first_pop(output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (fifo_rd) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (fifo_rd !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fifo_rd: got %0b want 0", fifo_rd); end
    tests_run++;
    if (gray_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_gray_data: got %0d want 0", gray_data); end
    tests_run++;
    if (gray_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_gray_valid: got %0b want 0", gray_valid); end
    tests_run++;
    if (pix_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_pix_count: got %0d want 0", pix_count); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    bit ok;
    int c;
    int pops;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    gray_ready = 1'b1;
    push_pixel(8'd100, 8'd100, 8'd100);
    @(negedge clk);
    rst = 1'b0;
    find_first_pop(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL latency_first_pop: got none want pop"); end
    c = 0;
    pops = 1;
    while (ok && !gray_valid && c < 40) begin
      @(negedge clk);
      c++;
      if (fifo_rd) pops++;
    end
    tests_run++;
    if (c != 7) begin tests_failed++; $display("[TB] FAIL latency_cycles: got %0d want 7", c); end
    tests_run++;
    if (pops != 3) begin tests_failed++; $display("[TB] FAIL latency_pops: got %0d want 3", pops); end
    tests_run++;
    if (gray_data !== exp_q[0]) begin tests_failed++; $display("[TB] FAIL latency_data: got %0d want %0d", gray_data, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    tests_run++;
    if (pix_count !== 4'd1 || gray_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL latency_count: got count %0d valid %0b want count 1 valid 0", pix_count, gray_valid);
    end
  endtask

  task automatic test_primaries();
    bit ok;
    logic [7:0] want [4];
    logic [7:0] m;
    want = '{8'd76, 8'd149, 8'd28, 8'd18};
    exp_q.delete();
    do_reset();
    gray_ready = 1'b1;
    push_pixel(8'd255, 8'd0, 8'd0);
    push_pixel(8'd0, 8'd255, 8'd0);
    push_pixel(8'd0, 8'd0, 8'd255);
    push_pixel(8'd10, 8'd20, 8'd30);
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      m = exp_q.pop_front();
      tests_run++;
      if (!ok || gray_data !== want[k]) begin
        tests_failed++;
        $display("[TB] FAIL primaries_const[%0d]: got %0d valid %0b want %0d", k, gray_data, gray_valid, want[k]);
      end
      tests_run++;
      if (gray_data !== m) begin tests_failed++; $display("[TB] FAIL primaries_model[%0d]: got %0d want %0d", k, gray_data, m); end
      @(negedge clk);
    end
    tests_run++;
    if (pix_count !== 4'd4) begin tests_failed++; $display("[TB] FAIL primaries_count: got %0d want 4", pix_count); end
  endtask

  task automatic test_empty_stall();
    bit ok;
    int c;
    int bad_pops;
    exp_q.delete();
    do_reset();
    gray_ready = 1'b1;
    push(8'd10);
    push(8'd20);
    find_first_pop(ok);
    c = 0;
    bad_pops = 0;
    while (ok && c < 8) begin
      @(negedge clk);
      c++;
      if (c >= 4 && fifo_rd) bad_pops++;
    end
    @(posedge clk);
    #1;
    push(8'd30);
    while (ok && !gray_valid && c < 60) begin
      @(negedge clk);
      c++;
    end
    tests_run++;
    if (bad_pops != 0) begin tests_failed++; $display("[TB] FAIL stall_rd_while_empty: got %0d want 0", bad_pops); end
    tests_run++;
    if (!ok || c != 12) begin tests_failed++; $display("[TB] FAIL stall_latency: got %0d want 12", c); end
    tests_run++;
    if (gray_data !== ref_gray(10, 20, 30)) begin
      tests_failed++;
      $display("[TB] FAIL stall_data: got %0d want %0d", gray_data, ref_gray(10, 20, 30));
    end
    @(negedge clk);
    tests_run++;
    if (underflows != 0) begin tests_failed++; $display("[TB] FAIL stall_underflow: got %0d want 0", underflows); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int pulses;
    int bad_hold;
    logic [7:0] held;
    logic [7:0] m;
    exp_q.delete();
    do_reset();
    gray_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      push_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_valid(ok);
    held = gray_data;
    m = exp_q.pop_front();
    tests_run++;
    if (!ok || held !== m) begin tests_failed++; $display("[TB] FAIL bp_first: got %0d want %0d", held, m); end
    pulses = 0;
    bad_hold = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_rd) pulses++;
      if (gray_valid !== 1'b1 || gray_data !== held || pix_count !== 4'd0) bad_hold++;
    end
    tests_run++;
    if (pulses != 0) begin tests_failed++; $display("[TB] FAIL bp_rd_pulses: got %0d want 0", pulses); end
    tests_run++;
    if (bad_hold != 0) begin tests_failed++; $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", bad_hold); end
    gray_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (pix_count !== 4'd1) begin tests_failed++; $display("[TB] FAIL bp_release_count: got %0d want 1", pix_count); end
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      m = exp_q.pop_front();
      tests_run++;
      if (!ok || gray_data !== m) begin tests_failed++; $display("[TB] FAIL bp_drain[%0d]: got %0d want %0d", k, gray_data, m); end
      @(negedge clk);
    end
    tests_run++;
    if (pix_count !== 4'd3) begin tests_failed++; $display("[TB] FAIL bp_final_count: got %0d want 3", pix_count); end
  endtask

  task automatic test_reset_mid_pixel();
    bit ok;
    int c;
    exp_q.delete();
    do_reset();
    gray_ready = 1'b1;
    push(8'd200);
    push(8'd50);
    find_first_pop(ok);
    c = 0;
    while (ok && c < 4) begin
      @(negedge clk);
      c++;
    end
    rst = 1'b1;
    push_pixel(8'd0, 8'd255, 8'd0);
    #1;
    tests_run++;
    if (fifo_rd !== 1'b0 || gray_valid !== 1'b0 || gray_data !== 8'd0 || pix_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs: got rd %0b valid %0b data %0d count %0d want all 0",
               fifo_rd, gray_valid, gray_data, pix_count);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_valid(ok);
    tests_run++;
    if (!ok || gray_data !== 8'd149) begin tests_failed++; $display("[TB] FAIL midrst_data: got %0d want 149", gray_data); end
    void'(exp_q.pop_front());
    @(negedge clk);
    tests_run++;
    if (pix_count !== 4'd1) begin tests_failed++; $display("[TB] FAIL midrst_count: got %0d want 1", pix_count); end
    gray_ready = 1'b0;
    push_pixel(8'd9, 8'd9, 8'd9);
    wait_valid(ok);
    do_reset();
    #1;
    tests_run++;
    if (gray_valid !== 1'b0 || pix_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL outrst_drop: got valid %0b count %0d want 0 0", gray_valid, pix_count);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] m;
    logic [3:0] want_cnt;
    exp_q.delete();
    do_reset();
    gray_ready = 1'b1;
    for (int k = 0; k < 17; k++)
      push_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    for (int k = 1; k <= 17; k++) begin
      wait_valid(ok);
      m = exp_q.pop_front();
      tests_run++;
      if (!ok || gray_data !== m) begin tests_failed++; $display("[TB] FAIL wrap_data[%0d]: got %0d want %0d", k, gray_data, m); end
      @(negedge clk);
      want_cnt = 4'(k % 16);
      tests_run++;
      if (pix_count !== want_cnt) begin tests_failed++; $display("[TB] FAIL wrap_count[%0d]: got %0d want %0d", k, pix_count, want_cnt); end
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    bit pending;
    logic [7:0] prev;
    logic [7:0] m;
    int cycles;
    logic [3:0] want_cnt;
    exp_q.delete();
    do_reset();
    for (int k = 0; k < N; k++)
      push_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    pending = 1'b0;
    prev = 8'd0;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (pending) begin
        tests_run++;
        if (gray_valid !== 1'b1 || gray_data !== prev) begin
          tests_failed++;
          $display("[TB] FAIL rand_hold: got valid %0b data %0d want 1 %0d", gray_valid, gray_data, prev);
        end
      end
      gray_ready = 1'($urandom_range(0, 1));
      hold_empty = ($urandom_range(0, 3) == 0);
      #1;
      if (gray_valid && gray_ready) begin
        m = exp_q.pop_front();
        tests_run++;
        if (gray_data !== m) begin tests_failed++; $display("[TB] FAIL rand_data: got %0d want %0d", gray_data, m); end
      end
      pending = gray_valid && !gray_ready;
      prev = gray_data;
    end
    @(negedge clk);
    gray_ready = 1'b0;
    hold_empty = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL rand_timeout: got %0d pending want 0", exp_q.size()); end
    want_cnt = 4'(N % 16);
    tests_run++;
    if (pix_count !== want_cnt) begin tests_failed++; $display("[TB] FAIL rand_count: got %0d want %0d", pix_count, want_cnt); end
    tests_run++;
    if (underflows != 0) begin tests_failed++; $display("[TB] FAIL rand_underflow: got %0d want 0", underflows); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_primaries();
    test_empty_stall();
    test_backpressure();
    test_reset_mid_pixel();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_gray_reader.md
# fifo_gray_reader

Read-side consumer for the grayscale pipeline's byte FIFO. It pulls interleaved R, G, B bytes from the FIFO's read port, assembles one RGB pixel, converts it to a single luminance byte with fixed integer weights, and presents the result on a valid/ready output stream. It sits between the `fifo` read interface (RD/empty/dataOut) and the downstream grayscale sink, replacing bench-driven RD pulsing with a real drain engine.

## Interface
- `DATAWIDTH`, 8: width of FIFO bytes and of the gray output.
- `CNTWIDTH`, 16: width of the emitted-pixel counter.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd`  out  1  FIFO read strobe; one pop per cycle it is high.
- `fifo_data`  in  DATAWIDTH  FIFO dataOut; valid one cycle after the pop.
- `gray_data`  out  DATAWIDTH  luminance result.
- `gray_valid`  out  1  `gray_data` is valid.
- `gray_ready`  in  1  downstream accepts when high together with `gray_valid`.
- `pix_count`  out  CNTWIDTH  number of gray pixels accepted downstream since reset.

## Operation
- Byte order in the FIFO is R, G, B, R, G, B, ...; `ch_idx` (0..2) tracks the next channel.
- FSM states: S_FETCH, S_LATCH, S_CALC, S_OUT. Reset state S_FETCH, `ch_idx`=0.
- S_FETCH: `fifo_rd` = !`fifo_empty` (combinational, only in this state). If !`fifo_empty` -> S_LATCH, else stay.
- S_LATCH: `fifo_rd`=0; register `fifo_data` into channel reg `ch_idx`. If `ch_idx`==2 -> S_CALC with `ch_idx`<=0; else `ch_idx`++ and -> S_FETCH.
- S_CALC: `gray_data` <= (77*R + 150*G + 29*B) >> 8; -> S_OUT.
- S_OUT: `gray_valid`=1; when `gray_ready`: `pix_count`++ and -> S_FETCH; else hold `gray_data` stable.
- Arithmetic: weights are 8-bit unsigned constants summing to 256; sum held in DATAWIDTH+8 bits, unsigned, no rounding (truncate); result is sum[DATAWIDTH+7:8], always ≤ max byte, never saturates.
- `pix_count` wraps from 2^CNTWIDTH−1 to 0.
- No pop is ever issued while `fifo_empty`=1; no pop is issued in S_LATCH, S_CALC or S_OUT, so the FIFO is never underflowed and output backpressure stalls reading.

## Timing
- Reset values: `fifo_rd`=0, `gray_data`=0, `gray_valid`=0, `pix_count`=0; channel regs 0.
- Per byte: 2 cycles minimum (FETCH with pop, LATCH with capture); empty in FETCH adds one cycle per empty cycle.
- Latency: first pop at cycle 0 with FIFO non-empty throughout -> `gray_valid` rises at cycle 7 (pops at 0,2,4; CALC at 6).
- Sustained throughput with `gray_ready`=1: one pixel per 8 cycles.
- `gray_valid` is registered; once high it stays high with constant `gray_data` until the handshake edge.
- Reset mid-pixel: any partially gathered bytes are discarded (already popped bytes are lost), `ch_idx` returns to 0; reset in S_OUT drops the pending pixel and does not count it.
- `fifo_empty` toggling during S_LATCH has no effect; it is sampled only in S_FETCH.

## Structure
- Package `gray_pkg`: weight constants `W_R`=77, `W_G`=150, `W_B`=29, shift constant 8, FSM state enum (S_FETCH, S_LATCH, S_CALC, S_OUT), channel-index constants.
- Sub-module `gray_weigh`: combinational multiply-add-shift of (R,G,B) to one byte, parameterised on DATAWIDTH; the top level registers its output in S_CALC.

## Test plan
- FIFO preloaded with 100,100,100, `gray_ready`=1 -> `gray_data`=100, `gray_valid` high at cycle 7 after first pop, `pix_count`=1.
- Pure primaries 255,0,0 / 0,255,0 / 0,0,255 then 10,20,30 -> outputs 76, 149, 28, 18 in order, `pix_count`=4.
- FIFO empty after the G byte for 5 cycles -> `fifo_rd` stays 0 while empty, no underflow, output 18 appears 5 cycles later than nominal.
- `gray_ready`=0 for 10 cycles with FIFO full -> `gray_valid` and `gray_data` held, zero `fifo_rd` pulses, `pix_count` unchanged until ready rises.
- `rst` asserted after R,G captured, then FIFO supplies 0,255,0 -> output 149 (stale bytes discarded), all outputs 0 during reset.
- Force `pix_count` near wrap (CNTWIDTH=4, 16 pixels) -> count reads 15 then 0.
